// File: rtl/gf2_pkg.sv
// gf2_pkg -- shared widths and FSM encoding for the GF(2) polynomial divider.
// The widths match the 16x16 Karatsuba multiplier this block inverts.
package gf2_pkg;

   localparam int AW    = 31;  // dividend / quotient width (product width)
   localparam int BW    = 16;  // divisor width (multiplier operand width)
   localparam int RW    = 15;  // remainder width, deg r < deg b <= 15
   localparam int DEG_W = 4;   // holds a divisor degree 0..15
   localparam int J_W   = 5;   // holds a quotient bit position 0..30

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      DONE
   } state_t;

endpackage

// File: rtl/gf2_deg16.sv
// gf2_deg16 -- combinational priority encoder: degree of a 16-bit polynomial
// (index of its highest set bit) and a flag for the all-zero polynomial.
module gf2_deg16
   import gf2_pkg::*;
(
   input  logic [BW-1:0]    b,
   output logic [DEG_W-1:0] deg,
   output logic             zero
);

   // Scan upward so the highest set bit is the last one to write deg.
   always_comb begin
      // NOTE: every output gets a default before the loop so no latch is inferred.
      deg  = '0;
      zero = (b == '0);
      for (int i = 0; i < BW; i++) begin
         if (b[i]) deg = DEG_W'(i);
      end
   end

endmodule

// File: rtl/gf2_poly_div_31by16.sv
// gf2_poly_div_31by16 -- sequential GF(2) long division, one quotient bit per
// cycle: a = q*b ^ r with deg r < deg b. Valid/ready on both sides, one
// operation in flight at a time.
// Optional build macro GF2DIV_EARLY_EXIT_EN: start the scan at j = 30 - deg(b)
// instead of j = 30, skipping quotient positions that are zero by construction.
// Results are identical in both builds; only the latency differs.
module gf2_poly_div_31by16
   import gf2_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] a,
   input  logic [BW-1:0] b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] q,
   output logic [RW-1:0] r,
   output logic          dz
);

   state_t            state, state_next;
   logic [AW-1:0]     w;        // working remainder
   logic [AW-1:0]     q_reg;    // quotient under construction
   logic [BW-1:0]     b_reg;    // latched divisor
   logic [DEG_W-1:0]  deg_reg;  // latched divisor degree
   logic [J_W-1:0]    j;        // current quotient bit position
   logic              dz_reg;

   logic [DEG_W-1:0]  deg_in;
   logic              b_zero;
   logic [J_W-1:0]    j_start;
   logic [J_W:0]      pos;
   logic              hit;
   logic [AW-1:0]     b_shift;

   wire accept  = in_valid & in_ready;
   wire deliver = out_valid & out_ready;

   gf2_deg16 u_deg (
      .b    (b),
      .deg  (deg_in),
      .zero (b_zero)
   );

   // First quotient position visited for the operand being accepted.
   always_comb begin
`ifdef GF2DIV_EARLY_EXIT_EN
      j_start = J_W'(AW - 1) - J_W'(deg_in);
`else
      j_start = J_W'(AW - 1);
`endif
   end

   // One division step: the divisor's leading term lands on w[j+deg].
   always_comb begin
      pos     = {1'b0, j} + (J_W + 1)'(deg_reg);
      hit     = (pos <= (J_W + 1)'(AW - 1)) && w[pos[J_W-1:0]];
      b_shift = {{(AW - BW){1'b0}}, b_reg} << j;
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of the others.
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept)   state_next = b_zero ? DONE : ITER;
         ITER: if (j == '0)  state_next = DONE;
         DONE: if (deliver)  state_next = IDLE;
         default:            state_next = IDLE;
      endcase
   end

   // Output decode.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   assign q  = q_reg;
   assign r  = w[RW-1:0];
   assign dz = dz_reg;

   // Datapath: load on accept, one conditional XOR-subtract per ITER cycle.
   always_ff @(posedge clk) begin
      // NOTE: the result registers are reset because q/r/dz are visible ports
      // with defined reset values; nothing here is a memory array.
      if (rst) begin
         w       <= '0;
         q_reg   <= '0;
         b_reg   <= '0;
         deg_reg <= '0;
         j       <= '0;
         dz_reg  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               b_reg   <= b;
               deg_reg <= deg_in;
               j       <= j_start;
               q_reg   <= '0;
               dz_reg  <= b_zero;
               w       <= b_zero ? '0 : a;
            end
            ITER: begin
               if (hit) w <= w ^ b_shift;
               q_reg[j] <= hit;
               if (j != '0) j <= j - 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gf2_poly_div_31by16.sv
// tb_gf2_poly_div_31by16 -- self-checking bench for the GF(2) divider.
// Reference: textbook polynomial long division on degrees plus a carry-less
// multiply used to rebuild the dividend. Honours GF2DIV_EARLY_EXIT_EN for
// the expected latency. Latency is counted in clock edges after the accept
// edge until out_valid is seen high; a divide-by-zero result is already
// valid right after the accept edge, so the first handshake edge is t0+1.
module tb_gf2_poly_div_31by16;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [30:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [30:0] q;
   logic [14:0] r;
   logic        dz;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gf2_poly_div_31by16 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .q         (q),
      .r         (r),
      .dz        (dz)
   );

   // ---------------- reference model ----------------
   function automatic int poly_deg(input logic [46:0] p);
      int d = -1;
      for (int i = 0; i < 47; i++) if (p[i]) d = i;
      return d;
   endfunction

   function automatic logic [46:0] clmul(input logic [30:0] x, input logic [15:0] y);
      logic [46:0] acc = '0;
      for (int i = 0; i < 16; i++) if (y[i]) acc ^= {16'b0, x} << i;
      return acc;
   endfunction

   function automatic void ref_div(input logic [30:0] av, input logic [15:0] bv,
                                   output logic [30:0] qv, output logic [14:0] rv);
      logic [46:0] rem = {16'b0, av};
      logic [46:0] qq  = '0;
      int db = poly_deg({31'b0, bv});
      if (db >= 0) begin
         while (poly_deg(rem) >= db) begin
            int sh = poly_deg(rem) - db;
            rem ^= {31'b0, bv} << sh;
            qq[sh] = 1'b1;
         end
         qv = qq[30:0];
         rv = rem[14:0];
      end else begin
         qv = '0;
         rv = '0;
      end
   endfunction

   function automatic int exp_lat(input logic [15:0] bv);
      if (bv == 16'h0) return 0;
`ifdef GF2DIV_EARLY_EXIT_EN
      return 31 - poly_deg({31'b0, bv});
`else
      return 31;
`endif
   endfunction

   // ---------------- drivers ----------------
   task automatic run_op(input logic [30:0] av, input logic [15:0] bv,
                         output logic [30:0] qo, output logic [14:0] ro,
                         output logic dzo, output int lat);
      @(negedge clk);
      a = av; b = bv; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
      qo = q; ro = r; dzo = dz;
   endtask

   task automatic release_out();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || q !== 31'h0 || r !== 15'h0 || dz !== 1'b0) begin
         errors++;
         $display("FAIL reset: in_ready=%b out_valid=%b q=%h r=%h dz=%b, required 1 0 0 0 0",
                  in_ready, out_valid, q, r, dz);
      end
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [30:0] av [3] = '{31'h0000000F, 31'h7FFFFFFF, 31'h7FFFFFFF};
      logic [15:0] bv [3] = '{16'h0003, 16'h8000, 16'h0001};
      logic [30:0] qe [3] = '{31'h00000005, 31'h0000FFFF, 31'h7FFFFFFF};
      logic [14:0] re [3] = '{15'h0000, 15'h7FFF, 15'h0000};
      for (int k = 0; k < 3; k++) begin
         logic [30:0] qo; logic [14:0] ro; logic dzo; int lat;
         run_op(av[k], bv[k], qo, ro, dzo, lat);
         checks++;
         if (qo !== qe[k] || ro !== re[k] || dzo !== 1'b0) begin
            errors++;
            $display("FAIL directed[%0d] result: q=%h r=%h dz=%b, required q=%h r=%h dz=0",
                     k, qo, ro, dzo, qe[k], re[k]);
         end
         checks++;
         if (lat != exp_lat(bv[k])) begin
            errors++;
            $display("FAIL directed[%0d] latency: %0d, required %0d", k, lat, exp_lat(bv[k]));
         end
         release_out();
      end
   endtask

   task automatic test_div_by_zero();
      logic [30:0] qo; logic [14:0] ro; logic dzo; int lat;
      run_op(31'h12345678, 16'h0000, qo, ro, dzo, lat);
      checks++;
      if (dzo !== 1'b1 || qo !== 31'h0 || ro !== 15'h0) begin
         errors++;
         $display("FAIL div_by_zero result: dz=%b q=%h r=%h, required dz=1 q=0 r=0", dzo, qo, ro);
      end
      checks++;
      if (lat != 0) begin
         errors++;
         $display("FAIL div_by_zero latency: valid %0d edges after accept, required right after accept", lat);
      end
      release_out();
      // A following non-zero divide must clear the flag.
      run_op(31'h0000000F, 16'h0003, qo, ro, dzo, lat);
      checks++;
      if (dzo !== 1'b0 || qo !== 31'h5 || ro !== 15'h0) begin
         errors++;
         $display("FAIL dz_clear: dz=%b q=%h r=%h, required dz=0 q=5 r=0", dzo, qo, ro);
      end
      release_out();
   endtask

   task automatic test_backpressure();
      logic [30:0] qo; logic [14:0] ro; logic dzo; int lat;
      run_op(31'h0000000F, 16'h0003, qo, ro, dzo, lat);
      for (int c = 0; c < 10; c++) begin
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || q !== 31'h5 || r !== 15'h0) begin
            errors++;
            $display("FAIL backpressure cycle %0d: out_valid=%b in_ready=%b q=%h r=%h, required 1 0 5 0",
                     c, out_valid, in_ready, q, r);
         end
         @(posedge clk);
         #1;
      end
      release_out();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL backpressure release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [30:0] qo; logic [14:0] ro; logic dzo; int lat;
      @(negedge clk);
      a = 31'h7FFFFFFF; b = 16'h0001; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL busy: in_ready=%b out_valid=%b, required 0 0", in_ready, out_valid);
      end
      repeat (4) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_op: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
      end
      @(negedge clk) rst = 1'b0;
      run_op(31'h0000000F, 16'h0003, qo, ro, dzo, lat);
      checks++;
      if (qo !== 31'h5 || ro !== 15'h0 || dzo !== 1'b0 || lat != exp_lat(16'h0003)) begin
         errors++;
         $display("FAIL after_reset op: q=%h r=%h dz=%b lat=%0d, required q=5 r=0 dz=0 lat=%0d",
                  qo, ro, dzo, lat, exp_lat(16'h0003));
      end
      release_out();
   endtask

   task automatic test_random_exact(input int n);
      for (int k = 0; k < n; k++) begin
         logic [15:0] x, y; logic [30:0] qo; logic [14:0] ro; logic dzo; int lat;
         logic [46:0] prod;
         x = 16'($urandom) & 16'((32'h1 << $urandom_range(16, 1)) - 1);
         do y = 16'($urandom) & 16'((32'h1 << $urandom_range(16, 1)) - 1); while (y == 16'h0);
         prod = clmul({15'b0, x}, y);
         run_op(prod[30:0], y, qo, ro, dzo, lat);
         checks++;
         if (qo !== {15'b0, x} || ro !== 15'h0 || dzo !== 1'b0 || lat != exp_lat(y)) begin
            errors++;
            $display("FAIL random_exact x=%h y=%h: q=%h r=%h dz=%b lat=%0d, required q=%h r=0 dz=0 lat=%0d",
                     x, y, qo, ro, dzo, lat, {15'b0, x}, exp_lat(y));
         end
         release_out();
      end
   endtask

   task automatic test_random_general(input int n);
      for (int k = 0; k < n; k++) begin
         logic [30:0] av, qo, qe; logic [15:0] bv; logic [14:0] ro, re; logic dzo; int lat;
         av = 31'($urandom);
         do bv = 16'($urandom) & 16'((32'h1 << $urandom_range(16, 1)) - 1); while (bv == 16'h0);
         ref_div(av, bv, qe, re);
         run_op(av, bv, qo, ro, dzo, lat);
         checks++;
         if (qo !== qe || ro !== re || dzo !== 1'b0 || lat != exp_lat(bv)) begin
            errors++;
            $display("FAIL random_general a=%h b=%h: q=%h r=%h dz=%b lat=%0d, required q=%h r=%h dz=0 lat=%0d",
                     av, bv, qo, ro, dzo, lat, qe, re, exp_lat(bv));
         end
         checks++;
         if ((clmul(qo, bv) ^ {32'b0, ro}) !== {16'b0, av} ||
             poly_deg({32'b0, ro}) >= poly_deg({31'b0, bv})) begin
            errors++;
            $display("FAIL random_identity a=%h b=%h: q*b^r=%h deg_r=%0d, required %h with deg_r<%0d",
                     av, bv, clmul(qo, bv) ^ {32'b0, ro}, poly_deg({32'b0, ro}), av,
                     poly_deg({31'b0, bv}));
         end
         release_out();
      end
   endtask

   task automatic test_back_to_back();
      logic [30:0] av [4] = '{31'h00000003, 31'h40000000, 31'h00000000, 31'h2AAAAAAA};
      logic [15:0] bv [4] = '{16'h0003, 16'h0002, 16'hFFFF, 16'h0000};
      for (int k = 0; k < 4; k++) begin
         logic [30:0] qo, qe; logic [14:0] ro, re; logic dzo; int lat;
         ref_div(av[k], bv[k], qe, re);
         run_op(av[k], bv[k], qo, ro, dzo, lat);
         release_out();
         checks++;
         if (qo !== qe || ro !== re || dzo !== (bv[k] == 16'h0) || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back[%0d]: q=%h r=%h dz=%b in_ready=%b, required q=%h r=%h dz=%b in_ready=1",
                     k, qo, ro, dzo, in_ready, qe, re, bv[k] == 16'h0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_div_by_zero();
      test_backpressure();
      test_reset_mid_op();
      test_back_to_back();
      test_random_exact(400);
      test_random_general(400);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
